// File: rtl/iq_mod_core_pkg.sv
// Shared definitions for the BPSK/QPSK modulator: mode codes, FSM states and
// the carrier LUT peak helper.
package iq_mod_core_pkg;

   localparam logic MODE_BPSK = 1'b0;
   localparam logic MODE_QPSK = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Symmetric carrier peak: the most-negative code is never produced.
   function automatic int lut_peak(input int car_w);
      return (1 << (car_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/iq_mod_core_nco_sincos.sv
// Phase-accumulator NCO with a quarter-wave sine table; cos/sin come out one
// clock after the phase that produced them.
module nco_sincos
   import iq_mod_core_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8,
   parameter int CAR_W   = 8
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [PHASE_W-1:0]        fcw,
   output logic signed [CAR_W-1:0]   sin_q,
   output logic signed [CAR_W-1:0]   cos_q
);

   localparam int N    = 1 << LUT_AW;
   localparam int PEAK = lut_peak(CAR_W);

   // Taylor series keeps the table independent of tool support for $sin.
   function automatic logic [CAR_W-1:0] quarter_sine(input int idx);
      real x;
      real term;
      real acc;
      x    = 1.5707963267948966 * real'(idx) / real'(N);
      term = x;
      acc  = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      return CAR_W'($rtoi(acc * real'(PEAK) + 0.5));
   endfunction

   logic [CAR_W-1:0] lut [0:N];

   genvar gi;
   generate
      for (gi = 0; gi <= N; gi++) begin : g_lut
         localparam logic [CAR_W-1:0] ENTRY = quarter_sine(gi);
         assign lut[gi] = ENTRY;
      end
   endgenerate

   logic [PHASE_W-1:0]      phase_q, phase_d;
   logic [1:0]              quad;
   logic [LUT_AW:0]         addr_fwd, addr_mir;
   logic signed [CAR_W-1:0] fwd, mir, sin_d, cos_d;

   always_comb begin
      phase_d  = en ? phase_q + fcw : phase_q;
      quad     = phase_q[PHASE_W-1 -: 2];
      addr_fwd = {1'b0, phase_q[PHASE_W-3 -: LUT_AW]};
      addr_mir = (LUT_AW + 1)'(N) - addr_fwd;
      fwd      = signed'(lut[addr_fwd]);
      mir      = signed'(lut[addr_mir]);
      sin_d    = fwd;
      cos_d    = mir;
      // Entry N holds the peak so quadrant boundaries land exactly on 0/+-peak.
      case (quad)
         2'd0: begin sin_d = fwd;  cos_d = mir;  end
         2'd1: begin sin_d = mir;  cos_d = -fwd; end
         2'd2: begin sin_d = -fwd; cos_d = -mir; end
         default: begin sin_d = -mir; cos_d = fwd; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
      end else begin
         phase_q <= phase_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
      end
   end

endmodule

// File: rtl/iq_mod_core.sv
// BPSK/QPSK modulator: stream words in, bipolar I/Q symbols held SPS samples,
// mixed with the NCO as I*cos + Q*sin through a 3-stage pipeline.
module iq_mod_core
   import iq_mod_core_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int SPS     = 100,
   parameter int AMP_W   = 8,
   parameter int AMP     = 64,
   parameter int CAR_W   = 8,
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          mode,
   input  logic [PHASE_W-1:0]            fcw,
   input  logic [DATA_W-1:0]             s_tdata,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   output logic signed [AMP_W+CAR_W:0]   m_tdata,
   output logic                          m_tvalid,
   output logic                          underrun,
   input  logic                          clr_underrun
);

   localparam int CNT_W  = $clog2(SPS);
   localparam int BIT_W  = $clog2(DATA_W);
   localparam int PROD_W = AMP_W + CAR_W;
   localparam int OUT_W  = PROD_W + 1;
   localparam logic signed [AMP_W-1:0] SYM_POS = AMP_W'(AMP);
   localparam logic signed [AMP_W-1:0] SYM_NEG = -SYM_POS;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                mode_q, mode_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [CNT_W-1:0]    samp_q, samp_d;
   logic                started_q, started_d;
   logic                underrun_q, underrun_d;
   logic                ready, hs, last_sample, last_sym, underrun_set;

   logic signed [AMP_W-1:0]  sym_i_q, sym_i_d, sym_q_q, sym_q_d;
   logic signed [PROD_W-1:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
   logic signed [OUT_W-1:0]  m_tdata_q, m_tdata_d;
   logic                     v1_q, v1_d, v2_q, v2_d, m_tvalid_q, m_tvalid_d;
   logic signed [CAR_W-1:0]  nco_sin, nco_cos;

   nco_sincos #(
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW),
      .CAR_W   (CAR_W)
   ) u_nco (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .fcw   (fcw),
      .sin_q (nco_sin),
      .cos_q (nco_cos)
   );

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      mode_d       = mode_q;
      bit_d        = bit_q;
      samp_d       = samp_q;
      started_d    = started_q;
      sym_i_d      = '0;
      sym_q_d      = '0;
      underrun_set = 1'b0;

      last_sample = (samp_q == CNT_W'(SPS - 1));
      last_sym    = (mode_q == MODE_QPSK) ? (bit_q == BIT_W'(DATA_W - 2))
                                          : (bit_q == BIT_W'(DATA_W - 1));
      ready = (state_q == ST_IDLE) | (en & (state_q == ST_RUN) & last_sample & last_sym);
      hs    = s_tvalid & ready;

      case (state_q)
         ST_IDLE: begin
            // Zero symbols before the first word ever accepted are startup, not underrun.
            if (en && started_q) underrun_set = 1'b1;
         end
         default: begin
            if (en) begin
               sym_i_d = word_q[DATA_W-1] ? SYM_POS : SYM_NEG;
               if (mode_q == MODE_QPSK) sym_q_d = word_q[DATA_W-2] ? SYM_POS : SYM_NEG;
               if (last_sample) begin
                  samp_d = '0;
                  if (last_sym) begin
                     state_d = ST_IDLE;
                  end else if (mode_q == MODE_BPSK) begin
                     bit_d  = bit_q + BIT_W'(1);
                     word_d = word_q << 1;
                  end else begin
                     bit_d  = bit_q + BIT_W'(2);
                     word_d = word_q << 2;
                  end
               end else begin
                  samp_d = samp_q + CNT_W'(1);
               end
            end
         end
      endcase

      if (hs) begin
         state_d   = ST_RUN;
         word_d    = s_tdata;
         mode_d    = mode;
         bit_d     = '0;
         samp_d    = '0;
         started_d = 1'b1;
      end

      underrun_d = clr_underrun ? 1'b0 : (underrun_set | underrun_q);
   end

   always_comb begin
      v1_d       = en;
      v2_d       = v1_q;
      prod_i_d   = PROD_W'(sym_i_q) * PROD_W'(nco_cos);
      prod_q_d   = PROD_W'(sym_q_q) * PROD_W'(nco_sin);
      m_tvalid_d = v2_q;
      m_tdata_d  = v2_q ? (OUT_W'(prod_i_q) + OUT_W'(prod_q_q)) : m_tdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         mode_q     <= MODE_BPSK;
         bit_q      <= '0;
         samp_q     <= '0;
         started_q  <= 1'b0;
         underrun_q <= 1'b0;
         sym_i_q    <= '0;
         sym_q_q    <= '0;
         v1_q       <= 1'b0;
         prod_i_q   <= '0;
         prod_q_q   <= '0;
         v2_q       <= 1'b0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         mode_q     <= mode_d;
         bit_q      <= bit_d;
         samp_q     <= samp_d;
         started_q  <= started_d;
         underrun_q <= underrun_d;
         sym_i_q    <= sym_i_d;
         sym_q_q    <= sym_q_d;
         v1_q       <= v1_d;
         prod_i_q   <= prod_i_d;
         prod_q_q   <= prod_q_d;
         v2_q       <= v2_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

   assign s_tready = ready & ~rst;
   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_iq_mod_core.sv
// Randomised bench for iq_mod_core against a symbol-queue reference model
// using real-valued sin/cos for the carrier.
module tb_iq_mod_core;

   localparam int DATA_W  = 8;
   localparam int SPS     = 4;
   localparam int AMP_W   = 8;
   localparam int AMP     = 64;
   localparam int CAR_W   = 8;
   localparam int PHASE_W = 24;
   localparam int LUT_AW  = 8;
   localparam int OUT_W   = AMP_W + CAR_W + 1;
   localparam int PEAK    = (1 << (CAR_W - 1)) - 1;
   localparam int unsigned PH_MASK = (1 << PHASE_W) - 1;

   logic clk = 1'b0;
   logic rst, en, mode, s_tvalid, clr_underrun;
   logic [PHASE_W-1:0] fcw;
   logic [DATA_W-1:0]  s_tdata;
   logic s_tready, m_tvalid, underrun;
   logic signed [OUT_W-1:0] m_tdata;

   always #5 clk = ~clk;

   iq_mod_core #(
      .DATA_W (DATA_W), .SPS (SPS), .AMP_W (AMP_W), .AMP (AMP),
      .CAR_W (CAR_W), .PHASE_W (PHASE_W), .LUT_AW (LUT_AW)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .mode (mode), .fcw (fcw),
      .s_tdata (s_tdata), .s_tvalid (s_tvalid), .s_tready (s_tready),
      .m_tdata (m_tdata), .m_tvalid (m_tvalid), .underrun (underrun),
      .clr_underrun (clr_underrun)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending symbols, samples left in the head symbol, NCO phase.
   int          sym_i[$];
   int          sym_q[$];
   int          rem;
   bit          started, m_under;
   int unsigned phase;
   bit          pv0, pv1, exp_valid;
   int          pd0, pd1, exp_data;

   function automatic int car(input int unsigned ph, input bit use_sin);
      real th, v;
      th = 6.283185307179586 * real'(ph >> (PHASE_W - LUT_AW - 2)) / real'(1 << (LUT_AW + 2));
      v  = real'(PEAK) * (use_sin ? $sin(th) : $cos(th));
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   function automatic int amp_of(input logic b);
      return b ? AMP : -AMP;
   endfunction

   function automatic bit mdl_ready();
      return (sym_i.size() == 0) || (en && sym_i.size() == 1 && rem == 1);
   endfunction

   task automatic mdl_reset();
      sym_i.delete(); sym_q.delete();
      rem = SPS; started = 0; m_under = 0; phase = 0;
      pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; exp_valid = 0; exp_data = 0;
   endtask

   task automatic mdl_clock();
      bit rdy, uset;
      int v;
      if (rst) begin mdl_reset(); return; end
      rdy  = mdl_ready();
      uset = 0;
      exp_valid = pv1;
      if (pv1) exp_data = pd1;
      pv1 = pv0; pd1 = pd0; pv0 = 0;
      if (en) begin
         if (sym_i.size() == 0) begin
            v = 0;
            if (started) uset = 1;
         end else begin
            v = sym_i[0] * car(phase, 0) + sym_q[0] * car(phase, 1);
            rem--;
            if (rem == 0) begin void'(sym_i.pop_front()); void'(sym_q.pop_front()); rem = SPS; end
         end
         pv0 = 1; pd0 = v;
         phase = (phase + fcw) & PH_MASK;
      end
      if (clr_underrun) m_under = 0;
      else if (uset) m_under = 1;
      if (s_tvalid && rdy) begin
         started = 1;
         if (mode) begin
            for (int k = 0; k < DATA_W / 2; k++) begin
               sym_i.push_back(amp_of(s_tdata[DATA_W-1-2*k]));
               sym_q.push_back(amp_of(s_tdata[DATA_W-2-2*k]));
            end
         end else begin
            for (int k = 0; k < DATA_W; k++) begin
               sym_i.push_back(amp_of(s_tdata[DATA_W-1-k]));
               sym_q.push_back(0);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      mdl_clock();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      en = 0; s_tvalid = 0; clr_underrun = 0;
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %0b want 1", s_tready); end
      for (int c = 0; c < 31; c++) begin
         en = 1; mode = 1; fcw = 24'h0A3D71; clr_underrun = 0;
         s_tvalid = (c == 2 || c == 24); s_tdata = DATA_W'($urandom);
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL reset_pre ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL reset_pre valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL reset_pre data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL reset_pre underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
      end
      #2 rst = 1;
      #1;
      checks += 4;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_async valid: got %0b want 0", m_tvalid); end
      if (m_tdata !== '0) begin errors++; $display("FAIL reset_async data: got %0d want 0", m_tdata); end
      if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_async ready: got %0b want 0", s_tready); end
      if (underrun !== 1'b0) begin errors++; $display("FAIL reset_async underrun: got %0b want 0", underrun); end
      step(); step();
      rst = 0; en = 0; s_tvalid = 0;
      #1;
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release ready: got %0b want 1", s_tready); end
      for (int c = 0; c < 6; c++) begin
         en = 1;
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL reset_post valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL reset_post data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL reset_post underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
      end
   endtask

   task automatic test_qpsk_fs4();
      int exp4[4] = '{8128, -8128, -8128, 8128};
      int nv = 0;
      pulse_reset();
      for (int c = 0; c < 14; c++) begin
         mode = 1; fcw = 24'(1 << 22);
         en = (c > 0); s_tvalid = (c == 0);
         s_tdata = {2'b10, 6'($urandom)};
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL qpsk ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL qpsk valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL qpsk data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL qpsk underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
         if (m_tvalid === 1'b1 && nv < 4) begin
            checks++;
            if (m_tdata !== OUT_W'(exp4[nv])) begin errors++; $display("FAIL qpsk_fs4 sample %0d: got %0d want %0d", nv, m_tdata, exp4[nv]); end
            nv++;
         end
      end
      checks++;
      if (nv != 4) begin errors++; $display("FAIL qpsk_fs4 count: got %0d want 4", nv); end
   endtask

   task automatic test_bpsk();
      int pat[4] = '{8128, 0, -8128, 0};
      int nv = 0;
      pulse_reset();
      for (int c = 0; c < 37; c++) begin
         mode = 0; fcw = 24'(1 << 22);
         en = (c > 0); s_tvalid = (c == 0); s_tdata = 8'hFF;
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL bpsk ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL bpsk valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL bpsk data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL bpsk underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
         if (m_tvalid === 1'b1 && nv < 32) begin
            checks++;
            if (m_tdata !== OUT_W'(pat[nv % 4])) begin errors++; $display("FAIL bpsk_pattern sample %0d: got %0d want %0d", nv, m_tdata, pat[nv % 4]); end
            nv++;
         end
      end
      checks++;
      if (nv != 32) begin errors++; $display("FAIL bpsk count: got %0d want 32", nv); end
   endtask

   task automatic test_back_to_back();
      int hs_cnt = 0;
      pulse_reset();
      fcw = PHASE_W'($urandom);
      for (int c = 0; c < 80; c++) begin
         en = 1; s_tvalid = 1; s_tdata = DATA_W'($urandom); mode = 1'($urandom);
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL b2b ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         if (s_tready === 1'b1) hs_cnt++;
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL b2b valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL b2b data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL b2b underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
      end
      checks += 2;
      if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_no_underrun: got %0b want 0", underrun); end
      if (hs_cnt < 4) begin errors++; $display("FAIL b2b_words: got %0d want >=4", hs_cnt); end
   endtask

   task automatic test_underrun();
      pulse_reset();
      for (int c = 0; c < 28; c++) begin
         mode = 1; fcw = 24'h2AAAAB;
         en = 1; s_tvalid = (c == 0); s_tdata = DATA_W'($urandom);
         clr_underrun = (c == 26);
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL underrun ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL underrun valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL underrun data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL underrun flag cyc %0d: got %0b want %0b", c, underrun, m_under); end
         if (c == 25) begin
            checks++;
            if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %0b want 1", underrun); end
         end
         if (c == 26) begin
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr_wins: got %0b want 0", underrun); end
         end
      end
      clr_underrun = 0;
   endtask

   task automatic test_en_gaps();
      pulse_reset();
      for (int c = 0; c < 150; c++) begin
         en = (c % 3 == 2); s_tvalid = 1; s_tdata = DATA_W'($urandom); mode = 1'($urandom);
         fcw = (c < 75) ? 24'h051EB8 : 24'h1C71C7;
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL gaps ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL gaps valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL gaps data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL gaps underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
      end
   endtask

   task automatic test_random();
      pulse_reset();
      fcw = PHASE_W'($urandom);
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 3) != 0);
         s_tvalid = 1'($urandom);
         s_tdata = DATA_W'($urandom);
         mode = 1'($urandom);
         clr_underrun = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) fcw = PHASE_W'($urandom);
         #1;
         checks++;
         if (s_tready !== mdl_ready()) begin errors++; $display("FAIL random ready cyc %0d: got %0b want %0b", c, s_tready, mdl_ready()); end
         step();
         checks += 3;
         if (m_tvalid !== exp_valid) begin errors++; $display("FAIL random valid cyc %0d: got %0b want %0b", c, m_tvalid, exp_valid); end
         if (m_tdata !== OUT_W'(exp_data)) begin errors++; $display("FAIL random data cyc %0d: got %0d want %0d", c, m_tdata, exp_data); end
         if (underrun !== m_under) begin errors++; $display("FAIL random underrun cyc %0d: got %0b want %0b", c, underrun, m_under); end
      end
      clr_underrun = 0;
   endtask

   initial begin
      rst = 1; en = 0; mode = 0; fcw = '0; s_tdata = '0; s_tvalid = 0; clr_underrun = 0;
      mdl_reset();
      repeat (3) @(negedge clk);
      rst = 0;
      test_reset();
      test_qpsk_fs4();
      test_bpsk();
      test_back_to_back();
      test_underrun();
      test_en_gaps();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
